seq_word_encoder: RTL and testbench

Writer-side counterpart of the sequencer word decoder.
- Accepts symbolic command/instruction fields over a valid/ready stream and packs them into seq_word_t.
- For jump instructions, converts an absolute target address into the relative jmp value plus direction bit.
- Writes the packed words into sequencer program memory at auto-incrementing addresses.
- Sits between the host/loader interface and the program RAM that the sequencer core fetches from.

---
 rtl/seq_word_encoder_pkg.sv | 81 ++++++++
 rtl/seq_word_encoder_jmp.sv | 36 +++
 rtl/seq_word_encoder.sv | 169 ++++++++++++++++
 tb/tb_seq_word_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_word_encoder_pkg.sv
// Shared sequencer word types and helpers for the program-memory word encoder.
// Word layout (MSB..LSB): cmd_type[1:0], instr[2:0], cnfg{rsvd[1:0], jmp_dir}, data[7:0].
package seq_word_encoder_pkg;

   localparam int DATA_W = 8;
   localparam int JMP_W  = 6;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      RUN_INSTR = 2'd1,
      CMD_WAIT  = 2'd2,
      CMD_HALT  = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      INSTR_NOP        = 3'd0,
      INSTR_WRITE      = 3'd1,
      INSTR_READ       = 3'd2,
      INSTR_COMP_JMP   = 3'd3,
      INSTR_UNCOND_JMP = 3'd4,
      INSTR_SET        = 3'd5,
      INSTR_CLR        = 3'd6,
      INSTR_TRIG       = 3'd7
   } instr_t;

   typedef logic [DATA_W-1:0] instr_data_t;

   typedef enum logic {
      JUMP_FWD  = 1'b0,
      JUMP_BACK = 1'b1
   } jmp_dir_t;

   typedef struct packed {
      logic [1:0] rsvd;
      jmp_dir_t   jmp_dir;
   } cnfg_t;

   typedef struct packed {
      cmd_t        cmd_type;
      instr_t      instr;
      cnfg_t       cnfg;
      instr_data_t data;
   } seq_word_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_JMP_RANGE = 2'd1,
      ERR_OVERFLOW  = 2'd2
   } enc_err_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      FLUSH  = 2'd2,
      ERROR  = 2'd3
   } enc_state_t;

   function automatic int get_word_width();
      return $bits(seq_word_t);
   endfunction

   function automatic int get_jmp_width();
      return JMP_W;
   endfunction

   function automatic logic is_jump_instr(input instr_t instr);
      return (instr == INSTR_COMP_JMP) || (instr == INSTR_UNCOND_JMP);
   endfunction

   // Non-RUN_INSTR commands carry no instruction, so that field is forced to NOP.
   function automatic seq_word_t build_word(input cmd_t cmd, input instr_t instr,
                                            input instr_data_t data);
      seq_word_t word;
      word          = '0;
      word.cmd_type = cmd;
      word.instr    = (cmd == RUN_INSTR) ? instr : INSTR_NOP;
      word.data     = data;
      return word;
   endfunction

endpackage

// File: rtl/seq_word_encoder_jmp.sv
// seq_jmp_resolve: turns an absolute jump target into a relative magnitude and
// direction for the word being written at the current write pointer.
module seq_jmp_resolve
   import seq_word_encoder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic [ADDR_W:0]   i_wr_ptr,
   input  logic [ADDR_W-1:0] i_target,
   output logic [JMP_W-1:0]  o_magnitude,
   output jmp_dir_t          o_dir,
   output logic              o_range_err
);

   localparam int unsigned JMP_MAX = (32'd1 << get_jmp_width()) - 32'd1;

   logic [ADDR_W:0] w_target_ext;
   logic [ADDR_W:0] w_diff;

   assign w_target_ext = {1'b0, i_target};

   always_comb begin
      if (w_target_ext < i_wr_ptr) begin
         o_dir  = JUMP_BACK;
         w_diff = i_wr_ptr - w_target_ext;
      end else begin
         o_dir  = JUMP_FWD;
         w_diff = w_target_ext - i_wr_ptr;
      end
   end

   // Range is judged on the full-width difference, before it is narrowed to the field.
   assign o_range_err = (32'(w_diff) > JMP_MAX);
   assign o_magnitude = JMP_W'(w_diff);

endmodule

// File: rtl/seq_word_encoder.sv
// Packs host field sets into sequencer words and writes them to program RAM.
// Optional running XOR checksum of written words: SEQ_WORD_ENCODER_CHECKSUM_EN.
module seq_word_encoder
   import seq_word_encoder_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic                        s_valid_i,
   output logic                        s_ready_o,
   input  cmd_t                        s_cmd_i,
   input  instr_t                      s_instr_i,
   input  instr_data_t                 s_data_i,
   input  logic [ADDR_W-1:0]           s_jmp_target_i,
   input  logic                        s_last_i,
   output logic                        mem_we_o,
   output logic [ADDR_W-1:0]           mem_addr_o,
   output logic [get_word_width()-1:0] mem_wdata_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic [1:0]                  err_code_o,
   output logic [ADDR_W:0]             words_o,
   output logic [get_word_width()-1:0] checksum_o
);

   localparam int              WORD_W   = get_word_width();
   localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

   enc_state_t        r_state;
   enc_err_t          r_err;
   logic              r_ready;
   logic              r_we;
   logic              r_done;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [ADDR_W:0]   r_wr_ptr;
   logic [ADDR_W:0]   r_words;

   logic              w_handshake;
   logic              w_jump;
   logic [JMP_W-1:0]  w_jmp_mag;
   jmp_dir_t          w_jmp_dir;
   logic              w_jmp_range_err;
   seq_word_t         w_word;

   seq_jmp_resolve #(
      .ADDR_W (ADDR_W)
   ) u_jmp_resolve (
      .i_wr_ptr    (r_wr_ptr),
      .i_target    (s_jmp_target_i),
      .o_magnitude (w_jmp_mag),
      .o_dir       (w_jmp_dir),
      .o_range_err (w_jmp_range_err)
   );

   assign w_handshake = s_valid_i && r_ready && (r_state == ACCEPT);
   assign w_jump      = (s_cmd_i == RUN_INSTR) && is_jump_instr(s_instr_i);

   always_comb begin
      w_word = build_word(s_cmd_i, s_instr_i, s_data_i);
      if (w_jump) begin
         w_word.data         = {{(DATA_W-JMP_W){1'b0}}, w_jmp_mag};
         w_word.cnfg.jmp_dir = w_jmp_dir;
      end
   end

   // start_i wins over everything else; a write registered in the previous cycle
   // is already on the memory port, so it still lands before the restart.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_err    <= ERR_NONE;
         r_ready  <= 1'b0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
         r_addr   <= BASE_PTR[ADDR_W-1:0];
         r_wdata  <= '0;
         r_wr_ptr <= BASE_PTR;
         r_words  <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         if (start_i) begin
            r_state  <= ACCEPT;
            r_err    <= ERR_NONE;
            r_ready  <= 1'b1;
            r_wr_ptr <= BASE_PTR;
            r_words  <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_ready <= 1'b0;
               end
               ACCEPT: begin
                  if (w_handshake) begin
                     if (w_jump && w_jmp_range_err) begin
                        r_err   <= ERR_JMP_RANGE;
                        r_state <= ERROR;
                        r_ready <= 1'b0;
                     end else begin
                        r_we     <= 1'b1;
                        r_addr   <= r_wr_ptr[ADDR_W-1:0];
                        r_wdata  <= w_word;
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        r_words  <= r_words + PTR_ONE;
                        if (s_last_i) begin
                           r_state <= FLUSH;
                           r_ready <= 1'b0;
                        end else if (r_wr_ptr == LAST_PTR) begin
                           r_err   <= ERR_OVERFLOW;
                           r_state <= ERROR;
                           r_ready <= 1'b0;
                        end
                     end
                  end
               end
               FLUSH: begin
                  r_done  <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= IDLE;
               end
               ERROR: begin
                  r_ready <= 1'b0;
               end
               default: begin
                  r_state <= IDLE;
                  r_ready <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SEQ_WORD_ENCODER_CHECKSUM_EN
   logic [WORD_W-1:0] r_checksum;

   // Folds in each word as it appears on the memory port, so it is complete by done_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_checksum <= '0;
      end else if (start_i) begin
         r_checksum <= '0;
      end else if (r_we) begin
         r_checksum <= r_checksum ^ r_wdata;
      end
   end

   assign checksum_o = r_checksum;
`else
   assign checksum_o = '0;
`endif

   assign s_ready_o   = r_ready;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign busy_o      = (r_state != IDLE);
   assign done_o      = r_done;
   assign err_o       = (r_err != ERR_NONE);
   assign err_code_o  = r_err;
   assign words_o     = r_words;

endmodule

// File: tb/tb_seq_word_encoder.sv
// Directed bench for seq_word_encoder: packing, jump resolution, errors, restart, reset.
module tb_seq_word_encoder;
   import seq_word_encoder_pkg::*;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rstN;
   logic              start;
   logic              sValid;
   logic              sReady;
   cmd_t              sCmd;
   instr_t            sInstr;
   logic [7:0]        sData;
   logic [ADDR_W-1:0] sTarget;
   logic              sLast;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [15:0]       memWdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        errCode;
   logic [ADDR_W:0]   words;
   logic [15:0]       checksum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_word_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk_i(clk), .rst_ni(rstN), .start_i(start),
      .s_valid_i(sValid), .s_ready_o(sReady), .s_cmd_i(sCmd), .s_instr_i(sInstr),
      .s_data_i(sData), .s_jmp_target_i(sTarget), .s_last_i(sLast),
      .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
      .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(errCode),
      .words_o(words), .checksum_o(checksum)
   );

   // Inputs change at the falling edge; outputs are read at the following falling edge.
   task automatic applyStimulus(input cmd_t c, input instr_t ins, input logic [7:0] d,
                                input logic [7:0] tgt, input logic last);
      sValid = 1'b1; sCmd = c; sInstr = ins; sData = d; sTarget = tgt; sLast = last;
      @(negedge clk);
   endtask

   task automatic dropValid();
      sValid = 1'b0; sLast = 1'b0;
   endtask

   task automatic startLoad();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (sReady !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", sReady); end
      total++; if (memWe !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b want=0", memWe); end
      total++; if (memAddr !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0h want=0", memAddr); end
      total++; if (memWdata !== 16'h0) begin bad++; $display("FAIL rst_wdata got=%0h want=0", memWdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
      total++; if (err !== 1'b0 || errCode !== 2'd0) begin bad++; $display("FAIL rst_err got=%0b/%0d want=0/0", err, errCode); end
      total++; if (words !== 9'd0) begin bad++; $display("FAIL rst_words got=%0d want=0", words); end
      total++; if (checksum !== 16'h0) begin bad++; $display("FAIL rst_checksum got=%0h want=0", checksum); end
      rstN = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0 || sReady !== 1'b0) begin bad++; $display("FAIL idle_after_rst busy=%0b ready=%0b want=0/0", busy, sReady); end
   endtask

   task automatic test_basic_load();
      startLoad();
      total++; if (sReady !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ld_start ready=%0b busy=%0b want=1/1", sReady, busy); end
      applyStimulus(RUN_INSTR, INSTR_NOP, 8'h00, 8'd0, 1'b0);
      total++; if (memWe !== 1'b1 || memAddr !== 8'd0) begin bad++; $display("FAIL ld_w0 we=%0b addr=%0h want=1/0", memWe, memAddr); end
      total++; if (memWdata !== 16'h4000) begin bad++; $display("FAIL ld_w0_data got=%0h want=4000", memWdata); end
      applyStimulus(RUN_INSTR, INSTR_NOP, 8'h00, 8'd0, 1'b0);
      total++; if (memWe !== 1'b1 || memAddr !== 8'd1) begin bad++; $display("FAIL ld_w1 we=%0b addr=%0h want=1/1", memWe, memAddr); end
      applyStimulus(RUN_INSTR, INSTR_UNCOND_JMP, 8'hAA, 8'd0, 1'b1);
      dropValid();
      total++; if (memWe !== 1'b1 || memAddr !== 8'd2) begin bad++; $display("FAIL ld_w2 we=%0b addr=%0h want=1/2", memWe, memAddr); end
      // back jump of 2 from address 2
      total++; if (memWdata !== 16'h6102) begin bad++; $display("FAIL ld_jmp_back got=%0h want=6102", memWdata); end
      total++; if (sReady !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ld_flush ready=%0b done=%0b want=0/0", sReady, done); end
      @(negedge clk);
      total++; if (done !== 1'b1 || memWe !== 1'b0) begin bad++; $display("FAIL ld_done done=%0b we=%0b want=1/0", done, memWe); end
      total++; if (words !== 9'd3 || busy !== 1'b0) begin bad++; $display("FAIL ld_words words=%0d busy=%0b want=3/0", words, busy); end
      @(negedge clk);
      total++; if (done !== 1'b0 || words !== 9'd3) begin bad++; $display("FAIL ld_hold done=%0b words=%0d want=0/3", done, words); end
   endtask

   task automatic test_jump_fwd();
      startLoad();
      applyStimulus(RUN_INSTR, INSTR_NOP, 8'h00, 8'd0, 1'b0);
      applyStimulus(RUN_INSTR, INSTR_COMP_JMP, 8'h00, 8'd5, 1'b0);
      total++; if (memAddr !== 8'd1 || memWdata !== 16'h5804) begin bad++; $display("FAIL jmp_fwd4 addr=%0h data=%0h want=1/5804", memAddr, memWdata); end
      applyStimulus(RUN_INSTR, INSTR_COMP_JMP, 8'hFF, 8'd2, 1'b0);
      total++; if (memAddr !== 8'd2 || memWdata !== 16'h5800) begin bad++; $display("FAIL jmp_self addr=%0h data=%0h want=2/5800", memAddr, memWdata); end
      applyStimulus(RUN_INSTR, INSTR_COMP_JMP, 8'h00, 8'd0, 1'b1);
      dropValid();
      total++; if (memAddr !== 8'd3 || memWdata !== 16'h5903) begin bad++; $display("FAIL jmp_back3 addr=%0h data=%0h want=3/5903", memAddr, memWdata); end
      @(negedge clk);
      total++; if (done !== 1'b1 || words !== 9'd4) begin bad++; $display("FAIL jmp_done done=%0b words=%0d want=1/4", done, words); end
   endtask

   task automatic test_jmp_range();
      startLoad();
      applyStimulus(RUN_INSTR, INSTR_UNCOND_JMP, 8'h00, 8'd64, 1'b1);
      total++; if (memWe !== 1'b0) begin bad++; $display("FAIL rng_no_write got=%0b want=0", memWe); end
      total++; if (err !== 1'b1 || errCode !== 2'd1) begin bad++; $display("FAIL rng_err got=%0b/%0d want=1/1", err, errCode); end
      total++; if (sReady !== 1'b0 || busy !== 1'b1 || words !== 9'd0) begin bad++; $display("FAIL rng_state ready=%0b busy=%0b words=%0d want=0/1/0", sReady, busy, words); end
      applyStimulus(RUN_INSTR, INSTR_NOP, 8'h00, 8'd0, 1'b0);
      total++; if (memWe !== 1'b0 || errCode !== 2'd1) begin bad++; $display("FAIL rng_hold we=%0b code=%0d want=0/1", memWe, errCode); end
      dropValid();
      startLoad();
      total++; if (err !== 1'b0 || errCode !== 2'd0 || sReady !== 1'b1) begin bad++; $display("FAIL rng_clear err=%0b code=%0d ready=%0b want=0/0/1", err, errCode, sReady); end
      applyStimulus(RUN_INSTR, INSTR_UNCOND_JMP, 8'h00, 8'd63, 1'b1);
      dropValid();
      total++; if (memWe !== 1'b1 || memWdata !== 16'h603F || err !== 1'b0) begin bad++; $display("FAIL rng_max we=%0b data=%0h err=%0b want=1/603f/0", memWe, memWdata, err); end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      int addrBad = 0;
      startLoad();
      for (int i = 0; i < 256; i++) begin
         applyStimulus(CMD_NOP, INSTR_NOP, 8'(i), 8'd0, 1'b0);
         total++;
         if (memWe !== 1'b1 || memAddr !== i[7:0] || memWdata !== {8'h00, i[7:0]}) begin
            bad++; addrBad++;
            if (addrBad < 4) $display("FAIL ovf_write%0d we=%0b addr=%0h data=%0h want=1/%0h/%0h", i, memWe, memAddr, memWdata, i[7:0], i[7:0]);
         end
      end
      total++; if (err !== 1'b1 || errCode !== 2'd2 || sReady !== 1'b0) begin bad++; $display("FAIL ovf_err err=%0b code=%0d ready=%0b want=1/2/0", err, errCode, sReady); end
      total++; if (words !== 9'd256) begin bad++; $display("FAIL ovf_words got=%0d want=256", words); end
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h55, 8'd0, 1'b0);
      total++; if (memWe !== 1'b0 || words !== 9'd256) begin bad++; $display("FAIL ovf_ignore we=%0b words=%0d want=0/256", memWe, words); end
      dropValid();
   endtask

   task automatic test_restart();
      startLoad();
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h11, 8'd0, 1'b0);
      dropValid();
      start = 1'b1;
      total++; if (memWe !== 1'b1 || memAddr !== 8'd0) begin bad++; $display("FAIL rs_pending we=%0b addr=%0h want=1/0", memWe, memAddr); end
      @(negedge clk);
      start = 1'b0;
      total++; if (memWe !== 1'b0 || words !== 9'd0 || sReady !== 1'b1) begin bad++; $display("FAIL rs_accept we=%0b words=%0d ready=%0b want=0/0/1", memWe, words, sReady); end
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h22, 8'd0, 1'b1);
      dropValid();
      total++; if (memAddr !== 8'd0 || memWdata !== 16'h0022) begin bad++; $display("FAIL rs_base addr=%0h data=%0h want=0/22", memAddr, memWdata); end
      startLoad();
      total++; if (done !== 1'b0 || busy !== 1'b1 || sReady !== 1'b1) begin bad++; $display("FAIL rs_flush done=%0b busy=%0b ready=%0b want=0/1/1", done, busy, sReady); end
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h33, 8'd0, 1'b1);
      dropValid();
      total++; if (memAddr !== 8'd0 || memWdata !== 16'h0033) begin bad++; $display("FAIL rs_again addr=%0h data=%0h want=0/33", memAddr, memWdata); end
      @(negedge clk);
      total++; if (done !== 1'b1 || words !== 9'd1) begin bad++; $display("FAIL rs_done done=%0b words=%0d want=1/1", done, words); end
   endtask

   task automatic test_back_to_back();
      logic pat [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] expAddr = 8'd0;
      startLoad();
      for (int i = 0; i < 10; i++) begin
         sValid = pat[i]; sCmd = CMD_NOP; sInstr = INSTR_NOP; sData = 8'(i + 1); sLast = 1'b0;
         @(negedge clk);
         total++; if (memWe !== pat[i]) begin bad++; $display("FAIL b2b_we%0d got=%0b want=%0b", i, memWe, pat[i]); end
         if (pat[i]) begin
            total++;
            if (memAddr !== expAddr || memWdata !== {8'h00, 8'(i + 1)}) begin
               bad++; $display("FAIL b2b_wr%0d addr=%0h data=%0h want=%0h/%0h", i, memAddr, memWdata, expAddr, i + 1);
            end
            expAddr++;
         end
      end
      total++; if (words !== 9'd6) begin bad++; $display("FAIL b2b_words got=%0d want=6", words); end
      sValid = 1'b1; sData = 8'h77;
      @(posedge clk);
      #2 rstN = 1'b0;
      #1;
      total++; if (memWe !== 1'b0 || busy !== 1'b0 || sReady !== 1'b0) begin bad++; $display("FAIL arst_ctrl we=%0b busy=%0b ready=%0b want=0/0/0", memWe, busy, sReady); end
      total++; if (words !== 9'd0 || memAddr !== 8'd0 || memWdata !== 16'h0) begin bad++; $display("FAIL arst_data words=%0d addr=%0h data=%0h want=0/0/0", words, memAddr, memWdata); end
      @(negedge clk);
      total++; if (memWe !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL arst_hold we=%0b done=%0b err=%0b want=0/0/0", memWe, done, err); end
      dropValid();
      rstN = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0 || memWe !== 1'b0) begin bad++; $display("FAIL arst_idle busy=%0b we=%0b want=0/0", busy, memWe); end
   endtask

   task automatic test_checksum();
      logic [15:0] expChk;
`ifdef SEQ_WORD_ENCODER_CHECKSUM_EN
      expChk = 16'h0007;
`else
      expChk = 16'h0000;
`endif
      startLoad();
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h01, 8'd0, 1'b0);
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h02, 8'd0, 1'b0);
      applyStimulus(CMD_NOP, INSTR_NOP, 8'h04, 8'd0, 1'b1);
      dropValid();
      total++; if (memWdata !== 16'h0004) begin bad++; $display("FAIL chk_w2 got=%0h want=4", memWdata); end
      @(negedge clk);
      total++; if (done !== 1'b1 || checksum !== expChk) begin bad++; $display("FAIL chk_done done=%0b chk=%0h want=1/%0h", done, checksum, expChk); end
      startLoad();
      total++; if (checksum !== 16'h0000) begin bad++; $display("FAIL chk_clear got=%0h want=0", checksum); end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN = 1'b0; start = 1'b0; sValid = 1'b0; sCmd = CMD_NOP; sInstr = INSTR_NOP;
      sData = 8'h00; sTarget = '0; sLast = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic_load();
      test_jump_fwd();
      test_jmp_range();
      test_overflow();
      test_restart();
      test_back_to_back();
      test_checksum();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
